// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module   : i2c_req_arbiter
// Purpose  : Round-robin arbiter that shares one I2C master between N_REQ
//            requesters. It latches the winning command, launches the master,
//            tracks busy/ack and returns status and read data to the winner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_req_arbiter #(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_rw,
   input  logic [7*N_REQ-1:0]   req_addr,
   input  logic [8*N_REQ-1:0]   req_block,
   input  logic [8*N_REQ-1:0]   req_wdata,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [7:0]           rdata,
   output logic [1:0]           err,
   output logic                 m_enable,
   output logic                 m_rw,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_block_addr,
   output logic [7:0]           m_data_in,
   input  logic                 m_busy,
   input  logic [7:0]           m_data_out,
   input  logic                 m_ack
);

   localparam int             PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int             CW       = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_LAST  = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0]  TO_MAX   = CW'(START_TIMEOUT);
   localparam logic [PW-1:0]  LAST_IDX = PW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   cur;
   logic [PW-1:0]   sel;
   logic [PW-1:0]   hi_idx;
   logic [PW-1:0]   lo_idx;
   logic            hi_found;
   logic            sel_rw;
   logic [6:0]      sel_addr;
   logic [7:0]      sel_block;
   logic [7:0]      sel_wdata;
   logic [CW-1:0]   to_cnt;
   logic            ack_seen;
   logic            ack_ok;
   logic            do_grant;
   logic            do_started;
   logic            do_timeout;
   logic            do_run_end;

   // Round-robin pick: lowest requester at/after ptr, otherwise lowest overall
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = PW'(i);
            if (PW'(i) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = PW'(i);
            end
         end
      end
      sel = hi_found ? hi_idx : lo_idx;
   end

   // Command fields of the selected requester
   always_comb begin
      sel_rw    = 1'b0;
      sel_addr  = '0;
      sel_block = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (PW'(i) == sel) begin
            sel_rw    = req_rw[i];
            sel_addr  = req_addr[7*i +: 7];
            sel_block = req_block[8*i +: 8];
            sel_wdata = req_wdata[8*i +: 8];
         end
      end
   end

   assign ack_ok = ack_seen | m_ack;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next state, datapath strobes and the completion pulse
   always_comb begin
      state_nx   = state;
      do_grant   = 1'b0;
      do_started = 1'b0;
      do_timeout = 1'b0;
      do_run_end = 1'b0;
      done       = '0;
      case (state)
         IDLE: begin
            // A master busy with someone else blocks new grants
            if ((|req) && !m_busy) begin
               do_grant = 1'b1;
               state_nx = LAUNCH;
            end
         end
         LAUNCH: begin
            if (m_busy) begin
               do_started = 1'b1;
               state_nx   = RUN;
            end else if (to_cnt == TO_LAST) begin
               do_timeout = 1'b1;
               state_nx   = FINISH;
            end
         end
         RUN: begin
            if (!m_busy) begin
               do_run_end = 1'b1;
               state_nx   = FINISH;
            end
         end
         FINISH: begin
            done     = gnt;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Grant, command latch, timeout counter and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt          <= '0;
         cur          <= '0;
         ptr          <= '0;
         m_enable     <= 1'b0;
         m_rw         <= 1'b0;
         m_addr       <= '0;
         m_block_addr <= '0;
         m_data_in    <= '0;
         rdata        <= '0;
         err          <= 2'b00;
         ack_seen     <= 1'b0;
         to_cnt       <= '0;
      end else begin
         if (do_grant) begin
            gnt          <= N_REQ'(1) << sel;
            cur          <= sel;
            m_rw         <= sel_rw;
            m_addr       <= sel_addr;
            m_block_addr <= sel_block;
            m_data_in    <= sel_wdata;
            m_enable     <= 1'b1;
            ack_seen     <= 1'b0;
            to_cnt       <= '0;
         end
         // Count cycles waiting for busy; saturate rather than wrap
         if (state == LAUNCH && !m_busy && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (do_started) begin
            m_enable <= 1'b0;
         end
         if (do_timeout) begin
            m_enable <= 1'b0;
            err      <= 2'b10;
         end
         if (state == RUN && m_ack) begin
            ack_seen <= 1'b1;
         end
         if (do_run_end) begin
            if (m_rw && ack_ok) begin
               rdata <= m_data_out;
            end
            err <= ack_ok ? 2'b00 : 2'b01;
         end
         if (state == FINISH) begin
            gnt <= '0;
            ptr <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Purpose  : Scoreboard bench for i2c_req_arbiter with a behavioural I2C
//            master responder and a round-robin service-order model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_req_arbiter;

   localparam int N  = 4;
   localparam int TO = 15;

   typedef struct {
      int         idx;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] blk;
      logic [7:0] wd;
      logic [1:0] err;
      logic [7:0] rd;
      int         en;
   } exp_t;

   typedef struct {
      bit         tmo;
      int         d;
      int         b;
      int         ack;
      logic [7:0] data;
   } beh_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   req_rw;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_block;
   logic [8*N-1:0] req_wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [7:0]     rdata;
   logic [1:0]     err;
   logic           m_enable;
   logic           m_rw;
   logic [6:0]     m_addr;
   logic [7:0]     m_block_addr;
   logic [7:0]     m_data_in;
   logic           m_busy;
   logic [7:0]     m_data_out;
   logic           m_ack;

   exp_t       exp_q[$];
   beh_t       beh_q[$];
   int         checks = 0;
   int         errors = 0;
   int         model_ptr = 0;
   logic [7:0] model_rdata = 8'h00;

   logic       f_rw   [N];
   logic [6:0] f_addr [N];
   logic [7:0] f_blk  [N];
   logic [7:0] f_wd   [N];
   beh_t       f_beh  [N];
   bit         f_drop [N];

   always #5 clk = ~clk;

   i2c_req_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_rw       (req_rw),
      .req_addr     (req_addr),
      .req_block    (req_block),
      .req_wdata    (req_wdata),
      .gnt          (gnt),
      .done         (done),
      .rdata        (rdata),
      .err          (err),
      .m_enable     (m_enable),
      .m_rw         (m_rw),
      .m_addr       (m_addr),
      .m_block_addr (m_block_addr),
      .m_data_in    (m_data_in),
      .m_busy       (m_busy),
      .m_data_out   (m_data_out),
      .m_ack        (m_ack)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   function automatic beh_t mk_beh(input bit tmo, input int d, input int b, input int ack,
                                   input logic [7:0] data);
      beh_t r;
      r.tmo = tmo; r.d = d; r.b = b; r.ack = ack; r.data = data;
      return r;
   endfunction

   // Reference model: service order is the first pending requester at or after
   // the rotating pointer; outcome follows from the master behaviour chosen.
   task automatic issue_round(input logic [N-1:0] mask);
      logic [N-1:0] pend;
      exp_t         e;
      int           j;
      pend = mask;
      while (pend != '0) begin
         j = -1;
         for (int k = 0; k < N; k++)
            if (j < 0 && pend[(model_ptr + k) % N]) j = (model_ptr + k) % N;
         pend[j] = 1'b0;
         e.idx = j; e.rw = f_rw[j]; e.addr = f_addr[j]; e.blk = f_blk[j]; e.wd = f_wd[j];
         if (f_beh[j].tmo) begin
            e.err = 2'b10;
            e.en  = TO;
         end else begin
            e.err = (f_beh[j].ack != 0) ? 2'b00 : 2'b01;
            e.en  = f_beh[j].d + 1;
            if (f_rw[j] && f_beh[j].ack != 0) model_rdata = f_beh[j].data;
         end
         e.rd = model_rdata;
         exp_q.push_back(e);
         beh_q.push_back(f_beh[j]);
         model_ptr = (j + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            req_rw[i]            = f_rw[i];
            req_addr[7*i +: 7]   = f_addr[i];
            req_block[8*i +: 8]  = f_blk[i];
            req_wdata[8*i +: 8]  = f_wd[i];
         end
      end
      req = req | mask;
   endtask

   task automatic wait_round();
      for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL round_complete pending=%0d expected=0", exp_q.size());
         exp_q.delete();
         beh_q.delete();
         req = '0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_setup();
      for (int i = 0; i < N; i++) begin
         f_rw[i] = 1'b0; f_addr[i] = '0; f_blk[i] = '0; f_wd[i] = '0;
         f_beh[i] = mk_beh(1'b0, 0, 2, 1, 8'h00);
         f_drop[i] = 1'b0;
      end
   endtask

   task automatic random_setup();
      for (int i = 0; i < N; i++) begin
         f_rw[i]   = 1'($urandom_range(0, 1));
         f_addr[i] = 7'($urandom);
         f_blk[i]  = 8'($urandom);
         f_wd[i]   = 8'($urandom);
         f_beh[i]  = mk_beh($urandom_range(0, 7) == 0, $urandom_range(0, 4),
                            $urandom_range(2, 6), $urandom_range(0, 2), 8'($urandom));
         f_drop[i] = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_m_enable", 32'(m_enable), 0);
      chk("rst_m_rw", 32'(m_rw), 0);
      chk("rst_m_addr", 32'(m_addr), 0);
      chk("rst_m_block_addr", 32'(m_block_addr), 0);
      chk("rst_m_data_in", 32'(m_data_in), 0);
   endtask

   // Requesters: drop req on done (or early after grant), scramble fields once granted
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (done[i] || (gnt[i] && f_drop[i])) req[i] = 1'b0;
            if (gnt[i]) begin
               req_rw[i]           = ~req_rw[i];
               req_addr[7*i +: 7]  = 7'($urandom);
               req_block[8*i +: 8] = 8'($urandom);
               req_wdata[8*i +: 8] = 8'($urandom);
            end
         end
      end
   end

   // Behavioural I2C master responding to m_enable
   initial begin
      beh_t bh;
      forever begin
         @(negedge clk);
         if (reset && m_enable && beh_q.size() != 0) begin
            bh = beh_q.pop_front();
            if (bh.tmo) begin
               for (int c = 0; c < 200 && m_enable; c++) @(negedge clk);
            end else begin
               repeat (bh.d) @(posedge clk);
               #1;
               m_busy     = 1'b1;
               m_ack      = 1'b0;
               m_data_out = 8'($urandom);
               for (int k = 1; k <= bh.b; k++) begin
                  @(posedge clk);
                  #1;
                  if (k < bh.b) begin
                     m_ack = (bh.ack == 1 && k == 1);
                  end else begin
                     m_busy     = 1'b0;
                     m_ack      = (bh.ack == 2);
                     m_data_out = bh.data;
                  end
               end
               @(posedge clk);
               #1;
               m_ack      = 1'b0;
               m_data_out = 8'($urandom);
            end
         end
      end
   end

   // Monitor: pop the scoreboard on each done pulse
   initial begin
      exp_t e;
      int   en_cnt;
      bit   prev_done;
      en_cnt    = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            en_cnt    = 0;
            prev_done = 1'b0;
         end else begin
            if (prev_done) begin
               chk("gnt_release", 32'(gnt), 0);
               chk("enable_gap", 32'(m_enable), 0);
               prev_done = 1'b0;
            end
            if (m_enable) en_cnt++;
            if (done != '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(done), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_idx", 32'(done), 32'(1) << e.idx);
                  chk("gnt_idx", 32'(gnt), 32'(1) << e.idx);
                  chk("err", 32'(err), 32'(e.err));
                  chk("rdata", 32'(rdata), 32'(e.rd));
                  chk("m_rw", 32'(m_rw), 32'(e.rw));
                  chk("m_addr", 32'(m_addr), 32'(e.addr));
                  chk("m_block_addr", 32'(m_block_addr), 32'(e.blk));
                  chk("m_data_in", 32'(m_data_in), 32'(e.wd));
                  chk("enable_cycles", 32'(en_cnt), 32'(e.en));
               end
               en_cnt    = 0;
               prev_done = 1'b1;
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_block = '0; req_wdata = '0;
      m_busy = 1'b0; m_ack = 1'b0; m_data_out = '0;
      clear_setup();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_values();
      @(negedge clk);
      reset = 1'b1;

      // Single write with grant latency
      clear_setup();
      f_addr[0] = 7'h69; f_blk[0] = 8'h8D; f_wd[0] = 8'h95;
      f_beh[0]  = mk_beh(1'b0, 2, 300, 1, 8'hEE);
      @(posedge clk); #1;
      issue_round(4'b0001);
      chk("grant_early", 32'(gnt), 0);
      @(posedge clk); #1;
      chk("grant_latency_gnt", 32'(gnt), 1);
      chk("grant_latency_en", 32'(m_enable), 1);
      wait_round();

      // Single read
      clear_setup();
      f_rw[2] = 1'b1; f_addr[2] = 7'h69; f_blk[2] = 8'h8D;
      f_beh[2] = mk_beh(1'b0, 1, 4, 2, 8'h5A);
      issue_round(4'b0100);
      wait_round();

      // Read without acknowledge
      clear_setup();
      f_rw[1] = 1'b1; f_addr[1] = 7'h22; f_blk[1] = 8'h10;
      f_beh[1] = mk_beh(1'b0, 0, 3, 0, 8'h33);
      issue_round(4'b0010);
      wait_round();

      // Start timeout
      clear_setup();
      f_rw[3] = 1'b1; f_addr[3] = 7'h11;
      f_beh[3] = mk_beh(1'b1, 0, 2, 1, 8'h77);
      issue_round(4'b1000);
      wait_round();

      // Round-robin with all requesters held
      clear_setup();
      for (int i = 0; i < N; i++) begin
         f_addr[i] = 7'(8'h40 + i); f_blk[i] = 8'(i); f_wd[i] = 8'(8'hA0 + i);
         f_beh[i]  = mk_beh(1'b0, i, 2 + i, 1, 8'(8'hC0 + i));
      end
      issue_round(4'b1111);
      wait_round();

      // Master busy in IDLE blocks grants
      clear_setup();
      f_addr[1] = 7'h05; f_wd[1] = 8'h5F;
      m_busy = 1'b1;
      issue_round(4'b0010);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_blocks_grant", 32'(gnt), 0);
      m_busy = 1'b0;
      wait_round();

      // Randomised rounds
      for (int r = 0; r < 30; r++) begin
         random_setup();
         issue_round(4'($urandom_range(1, 15)));
         wait_round();
      end

      // Leave ptr at 3 before the aborted transfer
      clear_setup();
      issue_round(4'b0100);
      wait_round();

      // Reset during RUN
      clear_setup();
      f_rw[1] = 1'b1; f_addr[1] = 7'h3C;
      f_beh[1] = mk_beh(1'b0, 1, 40, 1, 8'h99);
      issue_round(4'b0010);
      for (int c = 0; c < 50 && !m_busy; c++) @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_values();
      req = '0;
      exp_q.delete();
      beh_q.delete();
      model_ptr   = 0;
      model_rdata = 8'h00;
      for (int c = 0; c < 100 && m_busy; c++) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // After reset the pointer starts at 0: requester 0 before requester 3
      clear_setup();
      f_addr[3] = 7'h69; f_wd[3] = 8'h12;
      f_addr[0] = 7'h01; f_wd[0] = 8'h34;
      issue_round(4'b1001);
      wait_round();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
